// File: rtl/data_mem_responder_pkg.sv
// Shared pipeline definitions: datapath width, MEM-stage FSM states and the
// major opcodes used by the control decoder.
package data_mem_responder_pkg;

    localparam int PIPE_XLEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous data RAM, DEPTH x XLEN, write enable and registered
// read. Read-first: a read in the same cycle as a write returns the old word.
module dmem_array #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Array write on enable, registered read every cycle; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        rdata_o <= mem_q[idx_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one load or store at a time,
// stalls the pipeline for the array access, and reports completion/errors.
//
//   state     | meaning
//   ST_IDLE   | waiting; a request here is captured (stall while present)
//   ST_ACCESS | array access in flight, counter counts down to 0
//   ST_DONE   | completion cycle: rdata_valid (and mem_err) pulse, no stall
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int XLEN    = PIPE_XLEN,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            rdata_valid,
    output logic            mem_busy,
    output logic            mem_err
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XLEN-4:0] DEPTH_W  = (XLEN-3)'(DEPTH);
    localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);

    mem_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             req;
    logic             req_err;
    logic [XLEN-4:0]  word_full;
    logic [IDX_W-1:0] ram_idx;
    logic             ram_we;
    logic [XLEN-1:0]  ram_rdata;

    // Request decode, error classification, stall and RAM port steering.
    // In IDLE the RAM is addressed straight from the input so the registered
    // read is already valid after the first ACCESS edge, even with LATENCY=1.
    always_comb begin
        req       = mem_read | mem_write;
        word_full = addr[XLEN-1:3];
        req_err   = (addr[2:0] != 3'b000) || (word_full >= DEPTH_W) || (mem_read && mem_write);
        mem_busy  = ((state_q == ST_IDLE) && req) || (state_q == ST_ACCESS);
        ram_idx   = (state_q == ST_IDLE) ? addr[IDX_W+2:3] : idx_q;
        ram_we    = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && wr_q;
    end

    // Next-state logic; completion outputs are computed here and registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = addr[IDX_W+2:3];
                    wdata_d = wdata;
                    wr_d    = mem_write;
                    if (req_err) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // The request still visible in DONE is the one just completed.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_dmem_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign rdata       = rdata_q;
    assign rdata_valid = valid_q;
    assign mem_err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (XLEN=64, DEPTH=256, LATENCY=2).
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        mem_busy;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(
        .XLEN    (64),
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .mem_busy    (mem_busy),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [63:0] a;
        logic [63:0] d;
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Presents a request at a negedge and holds it through the completion
    // (DONE) cycle, as a stalled pipeline would. Cycle 0 is first presentation.
    task automatic do_req(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                          output int busy_n, output int vcyc, output logic err, output logic [63:0] rdv);
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        busy_n    = 0;
        vcyc      = -1;
        err       = 1'b0;
        rdv       = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mem_busy) busy_n++;
            if (rdata_valid) begin
                vcyc = c;
                err  = mem_err;
                rdv  = rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        #1;
    endtask

    initial begin
        int          busy_n;
        int          vcyc;
        logic        err;
        logic [63:0] rdv;

        vecs[0]  = '{"st_10",      1'b0, 1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0,                 3};
        vecs[1]  = '{"ld_10",      1'b1, 1'b0, 64'h10,  64'h0,                 1'b0, 64'hDEADBEEF_CAFEF00D, 3};
        vecs[2]  = '{"ld_mis_13",  1'b1, 1'b0, 64'h13,  64'h0,                 1'b1, 64'hDEADBEEF_CAFEF00D, 1};
        vecs[3]  = '{"st_20",      1'b0, 1'b1, 64'h20,  64'h01234567_89ABCDEF, 1'b0, 64'hDEADBEEF_CAFEF00D, 3};
        vecs[4]  = '{"both_20",    1'b1, 1'b1, 64'h20,  64'h1,                 1'b1, 64'hDEADBEEF_CAFEF00D, 1};
        vecs[5]  = '{"ld_20",      1'b1, 1'b0, 64'h20,  64'h0,                 1'b0, 64'h01234567_89ABCDEF, 3};
        vecs[6]  = '{"st_08",      1'b0, 1'b1, 64'h08,  64'h11112222_33334444, 1'b0, 64'h01234567_89ABCDEF, 3};
        vecs[7]  = '{"ld_oor_800", 1'b1, 1'b0, 64'h800, 64'h0,                 1'b1, 64'h01234567_89ABCDEF, 1};
        vecs[8]  = '{"st_7f8",     1'b0, 1'b1, 64'h7F8, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 64'h01234567_89ABCDEF, 3};
        vecs[9]  = '{"ld_7f8",     1'b1, 1'b0, 64'h7F8, 64'h0,                 1'b0, 64'hA5A5A5A5_5A5A5A5A, 3};
        vecs[10] = '{"ld_08",      1'b1, 1'b0, 64'h08,  64'h0,                 1'b0, 64'h11112222_33334444, 3};

        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rdata", rdata, 64'h0);
        check("rst_valid", {63'h0, rdata_valid}, 64'h0);
        check("rst_err",   {63'h0, mem_err}, 64'h0);
        check("rst_busy",  {63'h0, mem_busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, busy_n, vcyc, err, rdv);
            check({vecs[i].name, "_lat"},   64'(vcyc),   64'(vecs[i].exp_lat));
            check({vecs[i].name, "_busy"},  64'(busy_n), 64'(vecs[i].exp_lat));
            check({vecs[i].name, "_err"},   {63'h0, err}, {63'h0, vecs[i].exp_err});
            check({vecs[i].name, "_rdata"}, rdv,         vecs[i].exp_rdata);
            go_idle();
            check({vecs[i].name, "_pulse"}, {62'h0, rdata_valid, mem_err}, 64'h0);
            check({vecs[i].name, "_idle"},  {63'h0, mem_busy}, 64'h0);
        end

        // Reset during the last ACCESS cycle of a store to word 1.
        @(negedge clk);
        mem_write = 1'b1;
        addr      = 64'h08;
        wdata     = 64'h55;
        #1;
        check("rmid_busy0", {63'h0, mem_busy}, 64'h1);
        repeat (2) @(negedge clk);
        #1;
        check("rmid_busy2", {63'h0, mem_busy}, 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rmid_rdata", rdata, 64'h0);
        check("rmid_valid", {63'h0, rdata_valid}, 64'h0);
        check("rmid_err",   {63'h0, mem_err}, 64'h0);
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        #1;
        check("rmid_busy", {63'h0, mem_busy}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 64'h08, 64'h0, busy_n, vcyc, err, rdv);
        check("rmid_ld08_lat",   64'(vcyc), 64'd3);
        check("rmid_ld08_rdata", rdv, 64'h11112222_33334444);

        // Back-to-back: next request presented straight after DONE.
        do_req(1'b1, 1'b0, 64'h10, 64'h0, busy_n, vcyc, err, rdv);
        check("b2b_a_lat",   64'(vcyc), 64'd3);
        check("b2b_a_rdata", rdv, 64'hDEADBEEF_CAFEF00D);
        do_req(1'b1, 1'b0, 64'h7F8, 64'h0, busy_n, vcyc, err, rdv);
        check("b2b_b_lat",   64'(vcyc), 64'd3);
        check("b2b_b_busy",  64'(busy_n), 64'd3);
        check("b2b_b_rdata", rdv, 64'hA5A5A5A5_5A5A5A5A);
        do_req(1'b1, 1'b0, 64'h800, 64'h0, busy_n, vcyc, err, rdv);
        check("b2b_c_lat",   64'(vcyc), 64'd1);
        check("b2b_c_err",   {63'h0, err}, 64'h1);
        check("b2b_c_rdata", rdv, 64'hA5A5A5A5_5A5A5A5A);
        go_idle();
        check("b2b_end_idle", {61'h0, mem_busy, rdata_valid, mem_err}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
